// File: rtl/intcalc_seq.sv
// intcalc_seq: sequential integer unit. It computes the short ops (sign extend,
// complement, negate) in one cycle. Multiply and divide are radix-2 iterative
// and take WIDTH cycles, followed by one sign-fixup cycle.

package intcalc_pkg;

    typedef enum logic [3:0] {
        INT_EXT   = 4'd0,
        INT_EXTB  = 4'd1,
        INT_COM   = 4'd2,
        INT_NEG   = 4'd3,
        INT_MUL   = 4'd4,
        INT_MULU  = 4'd5,
        INT_MULX  = 4'd6,
        INT_MULUX = 4'd7,
        INT_DIV   = 4'd8,
        INT_MOD   = 4'd9,
        INT_DIVU  = 4'd10,
        INT_MODU  = 4'd11
    } intfunc_t;

    // Multiply and divide ops run through the iterative datapath
    function automatic logic func_is_long(input intfunc_t f);
        logic r;
        case (f)
            INT_MUL, INT_MULU, INT_MULX, INT_MULUX,
            INT_DIV, INT_MOD, INT_DIVU, INT_MODU: r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic func_is_div(input intfunc_t f);
        logic r;
        case (f)
            INT_DIV, INT_MOD, INT_DIVU, INT_MODU: r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    // Ops whose operands are treated as two's-complement
    function automatic logic func_is_signed(input intfunc_t f);
        logic r;
        case (f)
            INT_MUL, INT_MULX, INT_DIV, INT_MOD: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

module intcalc_seq
    import intcalc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  intfunc_t         func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             divzero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic               in_ready_r, out_valid_r;
    logic [WIDTH-1:0]   out_r;
    logic               divzero_r;
    intfunc_t           func_r;
    logic               neg_r;      // negate product / quotient in fixup
    logic               nega_r;     // negate remainder in fixup (sign of a)
    logic [CW-1:0]      count_r;
    logic [WIDTH-1:0]   mb_r;       // |b|: multiplicand or divisor
    logic [WIDTH-1:0]   hi_r;       // product high half / partial remainder
    logic [WIDTH-1:0]   lo_r;       // product low half / dividend-quotient

    logic               b_zero_s;
    logic               long_s;
    logic               sgn_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix_res_s;

    // Magnitude of v when treated as signed; MIN maps to 2^(WIDTH-1) unsigned
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // Result of ops that complete in a single cycle (including divide by zero)
    function automatic logic [WIDTH-1:0] short_result(input intfunc_t f,
                                                      input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        case (f)
            INT_EXT:           r = {{(WIDTH-16){x[15]}}, x[15:0]};
            INT_EXTB:          r = {{(WIDTH-8){x[7]}}, x[7:0]};
            INT_COM:           r = ~x;
            INT_NEG:           r = -x;
            INT_DIV, INT_DIVU: r = {WIDTH{1'b1}};
            INT_MOD, INT_MODU: r = x;
            default:           r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign divzero   = divzero_r;

    // Request decode: a divide by zero is finished immediately as a short op
    always_comb begin
        b_zero_s = (b == {WIDTH{1'b0}});
        sgn_s    = func_is_signed(func);
        long_s   = func_is_long(func) && !(func_is_div(func) && b_zero_s);
    end

    // One radix-2 step of shift-add multiply and restoring divide, plus fixup values
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mb_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, mb_r};
        prod_s      = neg_r ? -{hi_r, lo_r} : {hi_r, lo_r};
        quo_s       = neg_r ? -lo_r : lo_r;
        rem_s       = nega_r ? -hi_r : hi_r;
        case (func_r)
            INT_MUL, INT_MULU:   fix_res_s = prod_s[WIDTH-1:0];
            INT_MULX, INT_MULUX: fix_res_s = prod_s[2*WIDTH-1:WIDTH];
            INT_DIV, INT_DIVU:   fix_res_s = quo_s;
            INT_MOD, INT_MODU:   fix_res_s = rem_s;
            default:             fix_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state logic for IDLE -> (CALC -> FIXUP ->) DONE -> IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = long_s ? CALC : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (count_r == {CW{1'b0}}) begin
                    state_s = FIXUP;
                end else begin
                    state_s = CALC;
                end
            end
            FIXUP: state_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register with handshake flags registered alongside it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Operand capture, iterative datapath and result register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            func_r    <= INT_EXT;
            neg_r     <= 1'b0;
            nega_r    <= 1'b0;
            count_r   <= {CW{1'b0}};
            mb_r      <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            out_r     <= {WIDTH{1'b0}};
            divzero_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        func_r  <= func;
                        neg_r   <= sgn_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                        nega_r  <= sgn_s && a[WIDTH-1];
                        count_r <= CW'(WIDTH - 1);
                        mb_r    <= mag(b, sgn_s);
                        hi_r    <= {WIDTH{1'b0}};
                        lo_r    <= mag(a, sgn_s);
                        if (!long_s) begin
                            out_r     <= short_result(func, a);
                            divzero_r <= func_is_div(func) && b_zero_s;
                        end else begin
                            out_r     <= out_r;
                            divzero_r <= divzero_r;
                        end
                    end else begin
                        func_r <= func_r;
                    end
                end
                CALC: begin
                    if (func_is_div(func_r)) begin
                        hi_r <= div_diff_s[WIDTH] ? div_shift_s[WIDTH-1:0]
                                                  : div_diff_s[WIDTH-1:0];
                        lo_r <= {lo_r[WIDTH-2:0], ~div_diff_s[WIDTH]};
                    end else begin
                        hi_r <= mul_sum_s[WIDTH:1];
                        lo_r <= {mul_sum_s[0], lo_r[WIDTH-1:1]};
                    end
                    if (count_r != {CW{1'b0}}) begin
                        count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        count_r <= count_r;
                    end
                end
                FIXUP: begin
                    out_r     <= fix_res_s;
                    divzero_r <= 1'b0;
                end
                DONE: begin
                    out_r <= out_r;
                end
                default: begin
                    out_r <= out_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intcalc_seq.sv
// Testbench for intcalc_seq: directed and random requests are checked against
// a plain-arithmetic reference model through an expected-result queue.

module tb_intcalc_seq;
    import intcalc_pkg::*;

    logic        clk;
    logic        rst_i;
    intfunc_t    func;
    logic [31:0] a, b;
    logic        in_valid, in_ready;
    logic [31:0] out;
    logic        out_valid, out_ready, divzero;

    intcalc_seq #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .func(func), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready), .out(out),
        .out_valid(out_valid), .out_ready(out_ready), .divzero(divzero)
    );

    typedef struct {
        logic [31:0] res;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic hold = 1'b0;
    logic bp_val = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model written from the arithmetic definitions
    function automatic void model(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic dz, output int lat);
        longint      sx, sy, sp;
        logic [63:0] ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        sp = sx * sy;
        up = ux * uy;
        r = 32'd0; dz = 1'b0; lat = 34;
        case (f)
            INT_EXT:   begin r = 32'(longint'($signed(x[15:0]))); lat = 1; end
            INT_EXTB:  begin r = 32'(longint'($signed(x[7:0]))); lat = 1; end
            INT_COM:   begin r = ~x; lat = 1; end
            INT_NEG:   begin r = 32'(64'd0 - ux); lat = 1; end
            INT_MUL:   r = sp[31:0];
            INT_MULU:  r = up[31:0];
            INT_MULX:  r = sp[63:32];
            INT_MULUX: r = up[63:32];
            INT_DIV: begin
                if (y == 32'd0) begin r = 32'hFFFF_FFFF; dz = 1'b1; lat = 1; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
                else r = 32'(sx / sy);
            end
            INT_MOD: begin
                if (y == 32'd0) begin r = x; dz = 1'b1; lat = 1; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                else r = 32'(sx % sy);
            end
            INT_DIVU: begin
                if (y == 32'd0) begin r = 32'hFFFF_FFFF; dz = 1'b1; lat = 1; end
                else r = 32'(ux / uy);
            end
            INT_MODU: begin
                if (y == 32'd0) begin r = x; dz = 1'b1; lat = 1; end
                else r = 32'(ux % uy);
            end
            default: begin r = 32'd0; lat = 1; end
        endcase
    endfunction

    // Issue one request at a negedge; push the given expectation; return one negedge later
    task automatic issue(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input logic dz, input int lat);
        int   t;
        exp_t e;
        t = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'd0, 64'd1);
        end else begin
            func = intfunc_t'(f); a = x; b = y; in_valid = 1'b1;
            e.res = r; e.dz = dz; e.cyc = cyc + lat;
            q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0; a = $urandom; b = $urandom;
            func = intfunc_t'(4'($urandom_range(0, 15)));
        end
    endtask

    task automatic issue_model(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic        dz;
        int          lat;
        model(f, x, y, r, dz, lat);
        issue(f, x, y, r, dz, lat);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Consumer: random backpressure unless the main sequence holds it
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = hold ? bp_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare each presented result with the queue head, and hold-stability
    initial begin
        logic        seen;
        logic [31:0] held;
        logic        heldz;
        exp_t        e;
        seen = 1'b0; held = 32'd0; heldz = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1; held = out; heldz = divzero;
                    if (q.size() == 0) begin
                        check("unexpected_out_valid", 64'd1, 64'd0);
                    end else begin
                        e = q[0];
                        check("result", 64'(out), 64'(e.res));
                        check("divzero", 64'(divzero), 64'(e.dz));
                        check("latency_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end else begin
                    check("out_stable", 64'(out), 64'(held));
                    check("divzero_stable", 64'(divzero), 64'(heldz));
                end
                check("in_ready_low_in_done", 64'(in_ready), 64'd0);
                if (out_ready) begin
                    if (q.size() != 0) void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1; in_valid = 1'b0; func = INT_EXT; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out", 64'(out), 64'd0);
        check("reset_divzero", 64'(divzero), 64'd0);
        rst_i = 1'b0;

        // Directed vectors with hand-computed results
        issue(INT_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 34);
        issue(INT_MOD,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 34);
        issue(INT_MULX,  32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 1'b0, 34);
        issue(INT_MULUX, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34);
        issue(INT_MULU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 34);
        issue(INT_DIVU,  32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1'b1, 1);
        issue(INT_MODU,  32'h0000_1234, 32'd0,         32'h0000_1234, 1'b1, 1);
        issue(INT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34);
        issue(INT_MOD,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 34);
        issue(INT_EXTB,  32'h0000_0080, 32'd0,         32'hFFFF_FF80, 1'b0, 1);
        issue(INT_NEG,   32'h0000_0000, 32'd0,         32'h0000_0000, 1'b0, 1);
        issue(INT_EXT,   32'h1234_8001, 32'd0,         32'hFFFF_8001, 1'b0, 1);
        issue(4'd14,     32'h1234_5678, 32'd9,         32'h0000_0000, 1'b0, 1);

        // Random requests with biased operand classes
        for (int i = 0; i < 140; i++) begin
            logic [3:0]  f;
            logic [31:0] x, y;
            int          mode;
            f = 4'($urandom_range(0, 15));
            x = $urandom; y = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = $urandom_range(0, 200) - 100; y = $urandom_range(0, 20) - 10; end
                default: ;
            endcase
            issue_model(f, x, y);
        end
        drain();

        // Backpressure: hold out_ready low for 10 cycles with a competing request
        hold = 1'b1; bp_val = 1'b0;
        @(negedge clk);
        issue_model(INT_MULU, 32'd1234, 32'd5678);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("bp_out_valid_seen", 64'(out_valid), 64'd1);
        end
        for (int i = 0; i < 10; i++) begin
            func = INT_NEG; a = $urandom; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0; bp_val = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_queue_empty", 64'(q.size()), 64'd0);
        hold = 1'b0;
        drain();

        // Reset in the middle of a divide; a request during reset must be dropped
        issue_model(INT_DIV, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        rst_i = 1'b1; func = INT_MUL; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        rst_i = 1'b0; in_valid = 1'b0;
        q.delete();
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_out", 64'(out), 64'd0);
        check("midreset_divzero", 64'(divzero), 64'd0);
        @(negedge clk);
        check("reset_req_not_accepted", 64'(in_ready), 64'd1);
        repeat (40) @(negedge clk);
        issue(INT_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 34);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intcalc_seq.md
INTCALC_SEQ -- requirements
Module: intcalc_seq

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be even and >= 16.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high, sampled on clk_i.
REQ-004 func  input  intfunc_t (bexkat1Def)  operation select; sampled only on accept.
REQ-005 a  input  WIDTH  operand 1; interpreted signed or unsigned per func.
REQ-006 b  input  WIDTH  operand 2; interpreted signed or unsigned per func.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block can accept; high only in IDLE.
REQ-009 out  output  WIDTH  registered result.
REQ-010 out_valid  output  1  out is valid; held until out_ready.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 divzero  output  1  qualifies out; high when completed op was DIV/MOD/DIVU/MODU with b==0.

Function
REQ-013 Accept SHALL occur on a cycle with in_valid && in_ready; func, a, b captured into internal registers that cycle; later input changes ignored.
REQ-014 States: IDLE, CALC, FIXUP, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 Short ops (EXT, EXTB, COM, NEG, undefined func): IDLE -> DONE on accept; out_valid in cycle accept+1.
REQ-016 Long ops (MUL, MULU, MULX, MULUX, DIV, MOD, DIVU, MODU): IDLE -> CALC on accept; CALC lasts exactly WIDTH cycles (counter WIDTH-1 down to 0); then FIXUP 1 cycle; then DONE; out_valid in cycle accept+WIDTH+2.
REQ-017 Multiply SHALL be radix-2 shift-add on operand magnitudes into 2*WIDTH product; signed ops negate product in FIXUP when sign(a)^sign(b).
REQ-018 Divide SHALL be radix-2 restoring on magnitudes; signed quotient negated in FIXUP when sign(a)^sign(b); signed remainder takes sign of a (truncating division).
REQ-019 Result select: MUL/MULU low WIDTH bits; MULX/MULUX high WIDTH bits; DIV/DIVU quotient; MOD/MODU remainder.
REQ-020 EXT = a[15] replicated over bits WIDTH-1:16 with a[15:0]; EXTB = a[7] replicated over WIDTH-1:8 with a[7:0]; COM = ~a; NEG = two's complement of a mod 2^WIDTH; undefined func = 0.
REQ-021 Divide by zero detected on accept: treated as short op (DONE at accept+1); quotient = all ones; remainder = a; divzero=1.
REQ-022 Signed overflow DIV(MIN,-1) SHALL return MIN, MOD(MIN,-1) SHALL return 0, divzero=0, normal long latency.
REQ-023 In DONE, out/divzero stable while out_ready low; DONE -> IDLE on out_ready; in_valid that cycle not accepted (in_ready low), earliest next accept one cycle later.
REQ-024 divzero SHALL be 0 for every non-divide op.

Reset
REQ-025 rst_i high SHALL force state IDLE, out_valid=0, in_ready=1 on the following cycle, out=0, divzero=0, cycle counter=0.
REQ-026 Reset in any state (incl. mid-CALC or DONE under backpressure) SHALL discard the operation; no out_valid produced for it.
REQ-027 in_valid asserted during rst_i SHALL not be accepted.

Verification
REQ-028 WIDTH=32, DIV a=0xFFFFFFF9(-7) b=2 -> out=0xFFFFFFFD at accept+34; MOD same operands -> 0xFFFFFFFF; divzero=0.
REQ-029 MULX a=0x80000000 b=2 -> 0xFFFFFFFF; MULUX a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULU same -> 0x00000001; each at accept+34.
REQ-030 DIVU a=0x1234 b=0 -> out=0xFFFFFFFF, divzero=1 at accept+1; MODU a=0x1234 b=0 -> 0x00001234, divzero=1.
REQ-031 DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; MOD -> 0; EXTB a=0x00000080 -> 0xFFFFFF80; NEG a=0 -> 0.
REQ-032 Backpressure: out_ready low 10 cycles after DONE -> out constant, in_ready low, new in_valid ignored; out_ready high -> IDLE next cycle.
REQ-033 rst_i pulsed at accept+10 of DIV -> in_ready=1 next cycle, no out_valid; subsequent MUL 3*5 -> 15 at its accept+34.
